keypad_matrix_scanner: RTL and testbench
========================================

// Module: keypad_matrix_scanner
// PURPOSE
//  Parametrised column-scan driver for an NUM_COLS x NUM_ROWS matrix keypad; successor to the fixed 4x4 scanner.
//  Adds row synchronisation, press/release debounce, a one-cycle key event strobe, a linear key index and multi-key flag.
//  Sits between keypad pins and the key decoder/input FSM; downstream logic consumes key_valid + key_index.
// PARAMETERS
//  NUM_COLS     4           columns driven (>=2)
//  NUM_ROWS     4           rows sensed (>=2)
//  CLK_FREQ     27_000_000  clk_27mhz frequency, Hz
//  SCAN_FREQ    1900        full-matrix scan rate, Hz; SCAN_DIV = CLK_FREQ/(SCAN_FREQ*NUM_COLS) clocks per column
//  DEBOUNCE_MS  10          press/release stability window; DB_CYC = (CLK_FREQ/1000)*DEBOUNCE_MS
//  REPEAT_DLY_MS 500        first auto-repeat delay (used only with macro)
//  REPEAT_PER_MS 100        auto-repeat period (used only with macro)
// PORTS
//  clk_27mhz     in   1                   system clock
//  reset_n       in   1                   asynchronous reset, active low
//  keypad_cols   out  NUM_COLS            one-hot-low column drive
//  keypad_rows   in   NUM_ROWS            raw rows, pulled up, low = pressed
//  key_valid     out  1                   1-cycle strobe: debounced key event
//  key_index     out  $clog2(NUM_COLS*NUM_ROWS)  col*NUM_ROWS + row, stable from key_valid until next event
//  key_held      out  1                   high while debounced key is down (HELD, REL_DB)
//  key_code_raw  out  NUM_COLS+NUM_ROWS   {latched cols, latched rows}, all ones when idle
//  multi_key     out  1                   >1 row low in active column at latch time
// BEHAVIOUR
//  Reset (async, any state): col=0 so keypad_cols=~1, counters 0, state SCAN, key_valid=0, key_index=0,
//   key_held=0, key_code_raw all ones, multi_key=0. Mid-debounce/held reset drops the event; no strobe.
//  keypad_rows passes a 2-flop synchroniser (rows_s); all decisions use rows_s.
//  SCAN: scan_cnt counts 0..SCAN_DIV-1 per column; rows_s sampled only when scan_cnt==SCAN_DIV-1 (settling).
//   Sample all high -> col advances, wrap NUM_COLS-1 -> 0. Any low -> latch col, rows_s, lowest-index low row,
//   multi_key; column frozen; go PRESS_DB, db_cnt=0.
//  PRESS_DB: rows_s must equal latched rows every cycle; mismatch -> SCAN, clear latches, advance col.
//   db_cnt==DB_CYC-1 with match -> key_valid=1 next cycle, key_index updated same cycle, go HELD.
//  HELD: column frozen; rows_s all high -> REL_DB, db_cnt=0. Other row changes ignored.
//  REL_DB: any latched row low again -> HELD (no new strobe). db_cnt==DB_CYC-1 all high -> SCAN,
//   key_code_raw=all ones, multi_key=0, advance col. key_index retains last value.
//  Latency press->key_valid: <= NUM_COLS*SCAN_DIV + DB_CYC + 3 clocks.
//  Only one key tracked; keys in other columns invisible while HELD. Counters saturate-free, sized by $clog2.
// CONFIGURATION
//  KEYPAD_AUTOREPEAT_EN defined: in HELD, rpt_cnt counts; first extra key_valid after REPEAT_DLY_MS,
//   then every REPEAT_PER_MS, same key_index; rpt_cnt cleared on entering HELD and not running in REL_DB.
//  Undefined: exactly one key_valid per debounced press; REPEAT_* ignored, repeat logic absent.
// TESTING (CLK_FREQ=100_000, SCAN_FREQ=2500, DEBOUNCE_MS=1 -> SCAN_DIV=10, DB_CYC=100)
//  Reset: keypad_cols=4'b1110, key_code_raw=8'hFF, key_valid=0; cols cycle 1110,1101,1011,0111 every 10 clks.
//  Hold row1 on col2 for 300 clks -> one key_valid, key_index=9, key_code_raw=8'hBD, key_held=1.
//  Row glitch 40 clks in PRESS_DB -> no key_valid, return to SCAN, column advances to 3.
//  Release bounce (high 50, low 10, high 120) -> stays HELD, single release, key_held drops once.
//  Rows 0 and 2 low on col0 -> key_index=0, multi_key=1; reset_n low mid-HELD -> all reset values, no strobe.
//  With KEYPAD_AUTOREPEAT_EN, REPEAT_DLY_MS=2, REPEAT_PER_MS=1: hold 500 clks -> strobes at +0,+200,+300,+400.

Source files
------------

// File: rtl/keypad_matrix_scanner.sv
// ---------------------------------------------------------------------------
// keypad_matrix_scanner
//
// Column-scan driver for an NUM_COLS x NUM_ROWS matrix keypad. One column is
// driven low at a time; the pulled-up rows are synchronised and sampled at
// the end of each column slot, after the lines have had a full slot to settle.
// A low row latches the key and starts a press debounce. A key that stays
// stable for DB_CYC clocks produces a one-cycle key_valid strobe with its
// linear index. The key then stays held until the rows have been released
// for a full debounce window.
//
// Ports
//   clk_27mhz     in   system clock
//   reset_n       in   asynchronous reset, active low
//   keypad_cols   out  one-hot-low column drive
//   keypad_rows   in   raw rows, pulled up, low = pressed
//   key_valid     out  one-cycle strobe per debounced key event
//   key_index     out  col*NUM_ROWS + row, held until the next event
//   key_held      out  high while the debounced key is down
//   key_code_raw  out  {latched cols, latched rows}, all ones when idle
//   multi_key     out  more than one row low in the active column at latch
//
// Optional feature: define KEYPAD_AUTOREPEAT_EN to emit extra key_valid
// strobes while a key is held (first after REPEAT_DLY_MS, then every
// REPEAT_PER_MS). Without the macro there is exactly one strobe per press.
//
// Handshake: key_valid is a one-cycle strobe with no back-pressure; the
// consumer must capture key_index in the cycle key_valid is high (key_index
// also stays stable until the next strobe).
// ---------------------------------------------------------------------------
module keypad_matrix_scanner #(
  parameter int NUM_COLS      = 4,
  parameter int NUM_ROWS      = 4,
  parameter int CLK_FREQ      = 27_000_000,
  parameter int SCAN_FREQ     = 1900,
  parameter int DEBOUNCE_MS   = 10,
  parameter int REPEAT_DLY_MS = 500,
  parameter int REPEAT_PER_MS = 100
) (
  input  logic                                  clk_27mhz,
  input  logic                                  reset_n,
  output logic [NUM_COLS-1:0]                   keypad_cols,
  input  logic [NUM_ROWS-1:0]                   keypad_rows,
  output logic                                  key_valid,
  output logic [$clog2(NUM_COLS*NUM_ROWS)-1:0]  key_index,
  output logic                                  key_held,
  output logic [NUM_COLS+NUM_ROWS-1:0]          key_code_raw,
  output logic                                  multi_key
);

  localparam int SCAN_DIV = CLK_FREQ / (SCAN_FREQ * NUM_COLS);
  localparam int DB_CYC   = (CLK_FREQ / 1000) * DEBOUNCE_MS;
  localparam int COL_W    = $clog2(NUM_COLS);
  localparam int ROW_W    = $clog2(NUM_ROWS);
  localparam int IDX_W    = $clog2(NUM_COLS * NUM_ROWS);
  localparam int SCAN_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DB_W     = (DB_CYC > 1) ? $clog2(DB_CYC) : 1;

  localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(NUM_COLS - 1);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CYC - 1);
  localparam logic [IDX_W-1:0]  ROWS_IDX  = IDX_W'(NUM_ROWS);

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_PRESS_DB = 2'd1,
    ST_HELD     = 2'd2,
    ST_REL_DB   = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [NUM_ROWS-1:0] rows_meta, rows_s;
  logic [COL_W-1:0]    col;
  logic [SCAN_W-1:0]   scan_cnt;
  logic [DB_W-1:0]     db_cnt;
  logic [NUM_ROWS-1:0] lat_rows;
  logic [IDX_W-1:0]    lat_index;

  logic                rows_idle, rows_match, relatched;
  logic                scan_last, db_last;
  logic [NUM_ROWS-1:0] low_mask;
  logic [ROW_W-1:0]    low_row;
  logic                multi_now;
  logic                do_latch, do_fire, do_clear, do_advance;
  logic                rpt_fire;

  assign keypad_cols = ~(NUM_COLS'(1) << col);
  assign key_held    = (state_q == ST_HELD) || (state_q == ST_REL_DB);

  assign rows_idle  = &rows_s;
  assign rows_match = (rows_s == lat_rows);
  // A row that was part of the latched key has gone low again.
  assign relatched  = |(~rows_s & ~lat_rows);
  assign scan_last  = (scan_cnt == SCAN_LAST);
  assign db_last    = (db_cnt == DB_LAST);

  // x & (x-1) is non-zero exactly when more than one bit of x is set.
  assign low_mask  = ~rows_s;
  assign multi_now = |(low_mask & (low_mask - NUM_ROWS'(1)));

  // Lowest-index low row wins when several rows are low.
  always_comb begin
    low_row = '0;
    for (int i = NUM_ROWS - 1; i >= 0; i--) begin
      if (!rows_s[i]) low_row = ROW_W'(i);
    end
  end

  // Next state and the control strobes derived from the transition.
  always_comb begin
    state_d    = state_q;
    do_latch   = 1'b0;
    do_fire    = 1'b0;
    do_clear   = 1'b0;
    do_advance = 1'b0;
    case (state_q)
      ST_SCAN: begin
        if (scan_last) begin
          if (rows_idle) begin
            do_advance = 1'b1;
          end else begin
            state_d  = ST_PRESS_DB;
            do_latch = 1'b1;
          end
        end
      end
      ST_PRESS_DB: begin
        if (!rows_match) begin
          state_d    = ST_SCAN;
          do_clear   = 1'b1;
          do_advance = 1'b1;
        end else if (db_last) begin
          state_d = ST_HELD;
          do_fire = 1'b1;
        end
      end
      ST_HELD: begin
        if (rows_idle) state_d = ST_REL_DB;
      end
      ST_REL_DB: begin
        if (relatched) begin
          state_d = ST_HELD;
        end else if (rows_idle && db_last) begin
          state_d    = ST_SCAN;
          do_clear   = 1'b1;
          do_advance = 1'b1;
        end
      end
      default: state_d = ST_SCAN;
    endcase
  end

  always_ff @(posedge clk_27mhz or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_SCAN;
      rows_meta    <= '1;
      rows_s       <= '1;
      col          <= '0;
      scan_cnt     <= '0;
      db_cnt       <= '0;
      lat_rows     <= '1;
      lat_index    <= '0;
      key_code_raw <= '1;
      multi_key    <= 1'b0;
      key_valid    <= 1'b0;
      key_index    <= '0;
    end else begin
      state_q   <= state_d;
      rows_meta <= keypad_rows;
      rows_s    <= rows_meta;

      // Column slot timer only runs while scanning; every new column gets a
      // full slot of settling before its rows are sampled.
      if (state_q == ST_SCAN && !scan_last) scan_cnt <= scan_cnt + SCAN_W'(1);
      else                                  scan_cnt <= '0;

      if (do_advance) col <= (col == COL_LAST) ? '0 : col + COL_W'(1);

      // Debounce window restarts on every state change; during release it
      // also restarts whenever the rows are not all high.
      if (state_d != state_q)                 db_cnt <= '0;
      else if (state_q == ST_PRESS_DB)        db_cnt <= db_cnt + DB_W'(1);
      else if (state_q == ST_REL_DB && rows_idle) db_cnt <= db_cnt + DB_W'(1);
      else                                    db_cnt <= '0;

      if (do_latch) begin
        lat_rows     <= rows_s;
        lat_index    <= IDX_W'(col) * ROWS_IDX + IDX_W'(low_row);
        key_code_raw <= {keypad_cols, rows_s};
        multi_key    <= multi_now;
      end else if (do_clear) begin
        lat_rows     <= '1;
        key_code_raw <= '1;
        multi_key    <= 1'b0;
      end

      key_valid <= do_fire | rpt_fire;
      if (do_fire) key_index <= lat_index;
    end
  end

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int RPT_DLY = (CLK_FREQ / 1000) * REPEAT_DLY_MS;
  localparam int RPT_PER = (CLK_FREQ / 1000) * REPEAT_PER_MS;
  localparam int RPT_MAX = (RPT_DLY > RPT_PER) ? RPT_DLY : RPT_PER;
  localparam int RPT_W   = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;
  localparam logic [RPT_W-1:0] RPT_DLY_LAST = RPT_W'(RPT_DLY - 1);
  localparam logic [RPT_W-1:0] RPT_PER_LAST = RPT_W'(RPT_PER - 1);

  logic [RPT_W-1:0] rpt_cnt;
  logic             rpt_periodic;  // first repeat already issued

  assign rpt_fire = (state_q == ST_HELD) &&
                    (rpt_periodic ? (rpt_cnt == RPT_PER_LAST)
                                  : (rpt_cnt == RPT_DLY_LAST));

  // Outside HELD the counter is parked at zero, so entering HELD (from the
  // press debounce or a bounce back from release) restarts the delay.
  always_ff @(posedge clk_27mhz or negedge reset_n) begin
    if (!reset_n) begin
      rpt_cnt      <= '0;
      rpt_periodic <= 1'b0;
    end else if (state_q != ST_HELD) begin
      rpt_cnt      <= '0;
      rpt_periodic <= 1'b0;
    end else if (rpt_fire) begin
      rpt_cnt      <= '0;
      rpt_periodic <= 1'b1;
    end else begin
      rpt_cnt <= rpt_cnt + RPT_W'(1);
    end
  end
`else
  assign rpt_fire = 1'b0;
`endif

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// ---------------------------------------------------------------------------
// tb_keypad_matrix_scanner
//
// Directed bench for keypad_matrix_scanner with CLK_FREQ=100_000,
// SCAN_FREQ=2500, DEBOUNCE_MS=1 (SCAN_DIV=10, DB_CYC=100). A small key
// matrix model turns the set of pressed keys plus the column drive into the
// row levels seen by the scanner.
// ---------------------------------------------------------------------------
module tb_keypad_matrix_scanner;

  localparam int NC = 4;
  localparam int NR = 4;
  localparam int MAX_LAT = NC * 10 + 100 + 3;

  logic          clk;
  logic          reset_n;
  logic [NC-1:0] keypad_cols;
  logic [NR-1:0] keypad_rows;
  logic          key_valid;
  logic [3:0]    key_index;
  logic          key_held;
  logic [7:0]    key_code_raw;
  logic          multi_key;

  logic [NC*NR-1:0] keys;  // bit c*NR+r set = key at column c, row r pressed

  int pass_cnt, total_cnt;
  int cyc, strobe_cnt, last_valid_cyc, held_falls;
  logic prev_held;

  keypad_matrix_scanner #(
    .NUM_COLS    (NC),
    .NUM_ROWS    (NR),
    .CLK_FREQ    (100_000),
    .SCAN_FREQ   (2500),
    .DEBOUNCE_MS (1)
  ) dut (
    .clk_27mhz    (clk),
    .reset_n      (reset_n),
    .keypad_cols  (keypad_cols),
    .keypad_rows  (keypad_rows),
    .key_valid    (key_valid),
    .key_index    (key_index),
    .key_held     (key_held),
    .key_code_raw (key_code_raw),
    .multi_key    (multi_key)
  );

  // ---- clock / reset ------------------------------------------------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // ---- key matrix model ---------------------------------------------------
  always_comb begin
    keypad_rows = '1;
    for (int c = 0; c < NC; c++)
      for (int r = 0; r < NR; r++)
        if (keys[c*NR+r] && !keypad_cols[c]) keypad_rows[r] = 1'b0;
  end

  // ---- event monitor (sampled on the inactive edge) -----------------------
  always @(negedge clk) begin
    if (key_valid) begin
      strobe_cnt     <= strobe_cnt + 1;
      last_valid_cyc <= cyc;
    end
    if (prev_held && !key_held) held_falls <= held_falls + 1;
    prev_held <= key_held;
  end

  // ---- driver tasks -------------------------------------------------------
  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    keys    = '0;
    wait_clks(3);
    total_cnt++; if (keypad_cols !== 4'b1110) $display("FAIL reset_cols got=%b exp=1110", keypad_cols); else pass_cnt++;
    total_cnt++; if (key_code_raw !== 8'hFF) $display("FAIL reset_code got=%h exp=ff", key_code_raw); else pass_cnt++;
    total_cnt++; if (key_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", key_valid); else pass_cnt++;
    total_cnt++; if (key_held !== 1'b0 || multi_key !== 1'b0 || key_index !== 4'd0)
      $display("FAIL reset_misc got held=%b multi=%b idx=%0d exp 0/0/0", key_held, multi_key, key_index); else pass_cnt++;
    reset_n = 1'b1;
  endtask

  // Called right after reset release on a falling edge.
  task automatic test_col_cycle;
    logic [3:0] exp_cols [0:3];
    exp_cols[0] = 4'b1110; exp_cols[1] = 4'b1101; exp_cols[2] = 4'b1011; exp_cols[3] = 4'b0111;
    for (int i = 0; i < 4; i++) begin
      total_cnt++; if (keypad_cols !== exp_cols[i]) $display("FAIL col_start%0d got=%b exp=%b", i, keypad_cols, exp_cols[i]); else pass_cnt++;
      wait_clks(9);
      total_cnt++; if (keypad_cols !== exp_cols[i]) $display("FAIL col_end%0d got=%b exp=%b", i, keypad_cols, exp_cols[i]); else pass_cnt++;
      wait_clks(1);
    end
    total_cnt++; if (keypad_cols !== 4'b1110) $display("FAIL col_wrap got=%b exp=1110", keypad_cols); else pass_cnt++;
  endtask

  task automatic test_press_release;
    int s0, press_cyc, lat;
    s0 = strobe_cnt;
    press_cyc = cyc;
    keys[2*NR+1] = 1'b1;  // column 2, row 1
    wait_clks(300);
    lat = last_valid_cyc - press_cyc;
    total_cnt++; if (strobe_cnt - s0 !== 1) $display("FAIL press_strobes got=%0d exp=1", strobe_cnt - s0); else pass_cnt++;
    total_cnt++; if (lat < 100 || lat > MAX_LAT) $display("FAIL press_latency got=%0d exp=100..%0d", lat, MAX_LAT); else pass_cnt++;
    total_cnt++; if (key_index !== 4'd9) $display("FAIL press_index got=%0d exp=9", key_index); else pass_cnt++;
    total_cnt++; if (key_code_raw !== 8'hBD) $display("FAIL press_code got=%h exp=bd", key_code_raw); else pass_cnt++;
    total_cnt++; if (key_held !== 1'b1 || multi_key !== 1'b0)
      $display("FAIL press_held got held=%b multi=%b exp 1/0", key_held, multi_key); else pass_cnt++;
    keys = '0;
    wait_clks(150);
    total_cnt++; if (key_held !== 1'b0 || key_code_raw !== 8'hFF)
      $display("FAIL release got held=%b code=%h exp 0/ff", key_held, key_code_raw); else pass_cnt++;
    total_cnt++; if (key_index !== 4'd9 || strobe_cnt - s0 !== 1)
      $display("FAIL release_keep got idx=%0d strobes=%0d exp 9/1", key_index, strobe_cnt - s0); else pass_cnt++;
  endtask

  task automatic test_glitch;
    int s0, n;
    s0 = strobe_cnt;
    keys[2*NR+1] = 1'b1;
    n = 0;
    while (key_code_raw === 8'hFF && n < 100) begin
      wait_clks(1);
      n++;
    end
    total_cnt++; if (key_code_raw !== 8'hBD) $display("FAIL glitch_latch got=%h exp=bd", key_code_raw); else pass_cnt++;
    wait_clks(40);
    keys = '0;
    wait_clks(5);
    total_cnt++; if (keypad_cols !== 4'b0111) $display("FAIL glitch_col got=%b exp=0111", keypad_cols); else pass_cnt++;
    total_cnt++; if (key_code_raw !== 8'hFF || key_held !== 1'b0)
      $display("FAIL glitch_clear got code=%h held=%b exp ff/0", key_code_raw, key_held); else pass_cnt++;
    wait_clks(200);
    total_cnt++; if (strobe_cnt - s0 !== 0) $display("FAIL glitch_strobes got=%0d exp=0", strobe_cnt - s0); else pass_cnt++;
  endtask

  task automatic test_release_bounce;
    int s0, f0;
    s0 = strobe_cnt;
    keys[1*NR+3] = 1'b1;  // column 1, row 3
    wait_clks(300);
    f0 = held_falls;
    total_cnt++; if (strobe_cnt - s0 !== 1 || key_index !== 4'd7)
      $display("FAIL bounce_press got strobes=%0d idx=%0d exp 1/7", strobe_cnt - s0, key_index); else pass_cnt++;
    total_cnt++; if (key_code_raw !== 8'hD7) $display("FAIL bounce_code got=%h exp=d7", key_code_raw); else pass_cnt++;
    keys = '0;
    wait_clks(40);
    total_cnt++; if (key_held !== 1'b1) $display("FAIL bounce_reldb_held got=%b exp=1", key_held); else pass_cnt++;
    wait_clks(10);
    keys[1*NR+3] = 1'b1;
    wait_clks(5);
    total_cnt++; if (key_held !== 1'b1) $display("FAIL bounce_reheld got=%b exp=1", key_held); else pass_cnt++;
    wait_clks(5);
    keys = '0;
    wait_clks(120);
    total_cnt++; if (key_held !== 1'b0 || key_code_raw !== 8'hFF)
      $display("FAIL bounce_release got held=%b code=%h exp 0/ff", key_held, key_code_raw); else pass_cnt++;
    total_cnt++; if (held_falls - f0 !== 1) $display("FAIL bounce_falls got=%0d exp=1", held_falls - f0); else pass_cnt++;
    total_cnt++; if (strobe_cnt - s0 !== 1 || key_index !== 4'd7)
      $display("FAIL bounce_strobes got=%0d idx=%0d exp 1/7", strobe_cnt - s0, key_index); else pass_cnt++;
  endtask

  task automatic test_multi_key_reset;
    int s0;
    s0 = strobe_cnt;
    keys[0*NR+0] = 1'b1;
    keys[0*NR+2] = 1'b1;
    wait_clks(300);
    total_cnt++; if (strobe_cnt - s0 !== 1 || key_index !== 4'd0)
      $display("FAIL multi_press got strobes=%0d idx=%0d exp 1/0", strobe_cnt - s0, key_index); else pass_cnt++;
    total_cnt++; if (multi_key !== 1'b1) $display("FAIL multi_flag got=%b exp=1", multi_key); else pass_cnt++;
    total_cnt++; if (key_code_raw !== 8'hEA) $display("FAIL multi_code got=%h exp=ea", key_code_raw); else pass_cnt++;
    // Asynchronous reset while the key is held.
    s0 = strobe_cnt;
    reset_n = 1'b0;
    #1;
    total_cnt++; if (keypad_cols !== 4'b1110 || key_code_raw !== 8'hFF)
      $display("FAIL midreset_cols got cols=%b code=%h exp 1110/ff", keypad_cols, key_code_raw); else pass_cnt++;
    total_cnt++; if (key_held !== 1'b0 || multi_key !== 1'b0 || key_valid !== 1'b0)
      $display("FAIL midreset_flags got held=%b multi=%b valid=%b exp 0/0/0", key_held, multi_key, key_valid); else pass_cnt++;
    keys = '0;
    wait_clks(5);
    reset_n = 1'b1;
    wait_clks(200);
    total_cnt++; if (strobe_cnt - s0 !== 0 || key_index !== 4'd0)
      $display("FAIL midreset_quiet got strobes=%0d idx=%0d exp 0/0", strobe_cnt - s0, key_index); else pass_cnt++;
  endtask

  // ---- sequence and final report ------------------------------------------
  initial begin
    pass_cnt = 0; total_cnt = 0;
    cyc = 0; strobe_cnt = 0; last_valid_cyc = 0; held_falls = 0; prev_held = 1'b0;
    keys = '0;
    reset_n = 1'b0;
    @(negedge clk);
    test_reset;
    test_col_cycle;
    test_press_release;
    test_glitch;
    test_release_bounce;
    test_multi_key_reset;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired after %0d cycles", cyc);
    $fatal(1, "watchdog");
  end

endmodule
